// File: rtl/boron_req_arbiter.sv
// ---------------------------------------------------------------------------
// boron_req_arbiter
//
// Purpose:
//   Shares one BORON key-schedule + enc/dec core among NUM_REQ requesters.
//   A round-robin search picks the next owner. The block then drives the
//   core start handshake: keygen if needed, then encrypt or decrypt, then a
//   one-cycle completion ack back to the owner. Key ownership is cached, so
//   a repeat request from the same requester with a clean key skips keygen.
//
// Optional feature (compile-time macro BORON_ARB_TIMEOUT_EN):
//   Enables a watchdog that aborts an operation after TIMEOUT_CYCLES without
//   a done pulse and reports it on err instead of ack. Without the macro,
//   err is tied to zero and the block waits on done indefinitely.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   req          in   [NUM_REQ] per-requester request level
//   req_enc_dec  in   [NUM_REQ] per-requester mode, 1 = encrypt, 0 = decrypt
//   key_dirty    in   [NUM_REQ] requester key changed since its last keygen
//   key_done     in   core key schedule complete (pulse)
//   encdec_done  in   core enc/dec complete (pulse)
//   key_start    out  one-cycle keygen start pulse
//   enc_start    out  one-cycle encrypt start pulse
//   dec_start    out  one-cycle decrypt start pulse
//   grant        out  [NUM_REQ] one-hot owner of the core
//   grant_idx    out  [IDX_W] binary index of the owner
//   ack          out  [NUM_REQ] one-cycle completion pulse to the owner
//   err          out  [NUM_REQ] one-cycle watchdog error pulse to the owner
//   busy         out  high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module boron_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_enc_dec,
    input  logic [NUM_REQ-1:0] key_dirty,
    input  logic               key_done,
    input  logic               encdec_done,
    output logic               key_start,
    output logic               enc_start,
    output logic               dec_start,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] err,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        KEYGEN,
        CRYPT
    } state_t;

    // Catch parameter sets that cannot work at elaboration time rather than
    // letting the watchdog counter silently wrap or the index overflow.
    if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** IDX_W) < NUM_REQ ||
        TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : gParamCheck
        $error("boron_req_arbiter: inconsistent NUM_REQ/IDX_W/TIMEOUT_CYCLES/CNT_W");
    end

    state_t             r_state;
    logic               r_keyStart;
    logic               r_encStart;
    logic               r_decStart;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_grantIdx;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_busy;
    logic               r_mode;
    logic [IDX_W-1:0]   r_lastGrant;
    logic [IDX_W-1:0]   r_keyOwner;
    logic               r_keyOwnerValid;

    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [NUM_REQ-1:0] w_winnerOneHot;
    logic               w_needKey;

`ifdef BORON_ARB_TIMEOUT_EN
    logic [NUM_REQ-1:0] r_err;
    logic [CNT_W-1:0]   r_watchdog;
    logic [CNT_W-1:0]   w_wdNext;
    logic               w_timeout;
`endif

    // Round-robin search: walk upward from the slot after the last owner and
    // take the first requester found, wrapping past NUM_REQ-1 back to 0. The
    // modulo keeps this correct for requester counts that are not powers of 2.
    always_comb begin : winnerSearch
        int cand;
        cand     = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(r_lastGrant) + 1 + i) % NUM_REQ;
            if (!w_found && req[IDX_W'(cand)]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(cand);
            end
        end
    end

    // The cached key can only be reused when it is valid, belongs to the
    // winner, and the winner has not changed its key since.
    always_comb begin
        w_winnerOneHot = NUM_REQ'(1) << w_winner;
        w_needKey      = !r_keyOwnerValid || (r_keyOwner != w_winner) ||
                         key_dirty[w_winner];
    end

`ifdef BORON_ARB_TIMEOUT_EN
    // The watchdog fires on the edge where its count would reach the limit,
    // so err appears exactly TIMEOUT_CYCLES cycles after the start pulse.
    always_comb begin
        w_wdNext  = r_watchdog + CNT_W'(1);
        w_timeout = (w_wdNext == CNT_W'(TIMEOUT_CYCLES));
    end
`endif

    // Main control FSM. Every output is a register; the start/ack/err pulses
    // default low each cycle and are raised for a single cycle by the state
    // that issues them. Done inputs only act in the state that waits on them,
    // which is why a stray encdec_done in KEYGEN or key_done in CRYPT is
    // simply dropped. A done that coincides with the watchdog limit wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_keyStart      <= 1'b0;
            r_encStart      <= 1'b0;
            r_decStart      <= 1'b0;
            r_grant         <= '0;
            r_grantIdx      <= '0;
            r_ack           <= '0;
            r_busy          <= 1'b0;
            r_mode          <= 1'b0;
            r_lastGrant     <= IDX_W'(NUM_REQ - 1);
            r_keyOwner      <= '0;
            r_keyOwnerValid <= 1'b0;
`ifdef BORON_ARB_TIMEOUT_EN
            r_err           <= '0;
            r_watchdog      <= '0;
`endif
        end else begin
            r_keyStart <= 1'b0;
            r_encStart <= 1'b0;
            r_decStart <= 1'b0;
            r_ack      <= '0;
`ifdef BORON_ARB_TIMEOUT_EN
            r_err      <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_winnerOneHot;
                        r_grantIdx <= w_winner;
                        r_mode     <= req_enc_dec[w_winner];
                        r_busy     <= 1'b1;
`ifdef BORON_ARB_TIMEOUT_EN
                        r_watchdog <= '0;
`endif
                        if (w_needKey) begin
                            r_keyStart <= 1'b1;
                            r_state    <= KEYGEN;
                        end else begin
                            r_encStart <= req_enc_dec[w_winner];
                            r_decStart <= !req_enc_dec[w_winner];
                            r_state    <= CRYPT;
                        end
                    end
                end

                KEYGEN: begin
                    if (key_done) begin
                        r_encStart      <= r_mode;
                        r_decStart      <= !r_mode;
                        r_keyOwner      <= r_grantIdx;
                        r_keyOwnerValid <= 1'b1;
                        r_state         <= CRYPT;
`ifdef BORON_ARB_TIMEOUT_EN
                        r_watchdog      <= '0;
                    end else if (w_timeout) begin
                        r_err[r_grantIdx] <= 1'b1;
                        r_grant           <= '0;
                        r_grantIdx        <= '0;
                        r_busy            <= 1'b0;
                        r_keyOwnerValid   <= 1'b0;
                        r_lastGrant       <= r_grantIdx;
                        r_state           <= IDLE;
                    end else begin
                        r_watchdog <= w_wdNext;
`endif
                    end
                end

                CRYPT: begin
                    if (encdec_done) begin
                        r_ack[r_grantIdx] <= 1'b1;
                        r_grant           <= '0;
                        r_grantIdx        <= '0;
                        r_busy            <= 1'b0;
                        r_lastGrant       <= r_grantIdx;
                        r_state           <= IDLE;
`ifdef BORON_ARB_TIMEOUT_EN
                    end else if (w_timeout) begin
                        r_err[r_grantIdx] <= 1'b1;
                        r_grant           <= '0;
                        r_grantIdx        <= '0;
                        r_busy            <= 1'b0;
                        r_keyOwnerValid   <= 1'b0;
                        r_lastGrant       <= r_grantIdx;
                        r_state           <= IDLE;
                    end else begin
                        r_watchdog <= w_wdNext;
`endif
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Drive the ports straight from their registers.
    always_comb begin
        key_start = r_keyStart;
        enc_start = r_encStart;
        dec_start = r_decStart;
        grant     = r_grant;
        grant_idx = r_grantIdx;
        ack       = r_ack;
        busy      = r_busy;
`ifdef BORON_ARB_TIMEOUT_EN
        err       = r_err;
`else
        err       = '0;
`endif
    end

endmodule

// File: tb/tb_boron_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_boron_req_arbiter
//
// Directed bench for boron_req_arbiter with NUM_REQ = 4. A table of per-cycle
// vectors covers the basic keygen/encrypt flow, key reuse, round-robin order,
// key_dirty, stray done pulses and wrap-around. Hand-written sequences cover
// asynchronous reset mid-operation and, when BORON_ARB_TIMEOUT_EN is defined
// (with TIMEOUT_CYCLES = 16), the watchdog.
// ---------------------------------------------------------------------------
module tb_boron_req_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_enc_dec;
    logic [3:0] key_dirty;
    logic       key_done;
    logic       encdec_done;
    logic       key_start;
    logic       enc_start;
    logic       dec_start;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic [3:0] ack;
    logic [3:0] err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] encDec;
        logic [3:0] dirty;
        logic       keyDone;
        logic       encDone;
        logic       expKs;
        logic       expEs;
        logic       expDs;
        logic [3:0] expGrant;
        logic [3:0] expAck;
        logic       expBusy;
    } vecT;

    vecT vecs[$];

    boron_req_arbiter #(
        .NUM_REQ(4),
        .IDX_W(2),
        .TIMEOUT_CYCLES(16),
        .CNT_W(11)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_enc_dec(req_enc_dec),
        .key_dirty(key_dirty),
        .key_done(key_done),
        .encdec_done(encdec_done),
        .key_start(key_start),
        .enc_start(enc_start),
        .dec_start(dec_start),
        .grant(grant),
        .grant_idx(grant_idx),
        .ack(ack),
        .err(err),
        .busy(busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected binary index for a one-hot grant (zero when nothing is granted).
    function automatic logic [1:0] idxOf(input logic [3:0] g);
        case (g)
            4'b0010: idxOf = 2'd1;
            4'b0100: idxOf = 2'd2;
            4'b1000: idxOf = 2'd3;
            default: idxOf = 2'd0;
        endcase
    endfunction

    // Advance one clock and settle just past the rising edge, so outputs are
    // sampled away from the edge and new inputs are set up for the next one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] rq, input logic [3:0] ed,
                                 input logic [3:0] dk, input logic kd,
                                 input logic edn);
        req         = rq;
        req_enc_dec = ed;
        key_dirty   = dk;
        key_done    = kd;
        encdec_done = edn;
    endtask

    // Compare every output at once against the bench's expectation.
    task automatic checkOutput(input string name, input logic ks, input logic es,
                               input logic ds, input logic [3:0] g,
                               input logic [3:0] a, input logic [3:0] e,
                               input logic b);
        logic [17:0] act;
        logic [17:0] exp;
        act = {key_start, enc_start, dec_start, grant, grant_idx, ack, err, busy};
        exp = {ks, es, ds, g, idxOf(g), a, e, b};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got ks=%b es=%b ds=%b grant=%b idx=%0d ack=%b err=%b busy=%b, want ks=%b es=%b ds=%b grant=%b idx=%0d ack=%b err=%b busy=%b",
                     name, key_start, enc_start, dec_start, grant, grant_idx,
                     ack, err, busy, ks, es, ds, g, idxOf(g), a, e, b);
        end
    endtask

    // One cycle of a hand-written sequence: drive, clock, check.
    task automatic runVec(input string name, input logic [3:0] rq,
                          input logic [3:0] ed, input logic [3:0] dk,
                          input logic kd, input logic edn, input logic ks,
                          input logic es, input logic ds, input logic [3:0] g,
                          input logic [3:0] a, input logic [3:0] e,
                          input logic b);
        applyStimulus(rq, ed, dk, kd, edn);
        step();
        checkOutput(name, ks, es, ds, g, a, e, b);
    endtask

    // Idle cycles while an owner waits on the core: no pulses, grant held.
    task automatic waitHeld(input string name, input int n, input logic [3:0] g);
        for (int i = 0; i < n; i++) begin
            runVec(name, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, g, 4'b0, 4'b0, 1'b1);
        end
    endtask

    task automatic addVec(input logic [3:0] rq, input logic [3:0] ed,
                          input logic [3:0] dk, input logic kd, input logic edn,
                          input logic ks, input logic es, input logic ds,
                          input logic [3:0] g, input logic [3:0] a,
                          input logic b);
        vecT v;
        v.req      = rq;
        v.encDec   = ed;
        v.dirty    = dk;
        v.keyDone  = kd;
        v.encDone  = edn;
        v.expKs    = ks;
        v.expEs    = es;
        v.expDs    = ds;
        v.expGrant = g;
        v.expAck   = a;
        v.expBusy  = b;
        vecs.push_back(v);
    endtask

    task automatic addWait(input int n, input logic [3:0] g);
        for (int i = 0; i < n; i++) begin
            addVec(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, g, 4'b0, 1'b1);
        end
    endtask

    // Build the per-cycle vector table. Each entry's inputs are sampled by the
    // next rising edge and its expectations are checked just after that edge.
    task automatic buildTable();
        logic [3:0] g;
        // First request from 0, encrypt: keygen, key_done after 5 cycles,
        // encdec_done 10 cycles after enc_start, ack with grant dropping.
        addVec(4'b0001, 4'b0001, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0, 1'b1);
        addWait(4, 4'b0001);
        addVec(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0, 1'b1);
        addWait(9, 4'b0001);
        addVec(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0);
        // Repeat from 0, decrypt, clean key: straight to dec_start.
        addVec(4'b0001, 4'b0000, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0, 1'b1);
        addVec(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0);
        // All four held high after last_grant = 0: order 1,2,3,0, each keygen.
        for (int k = 1; k <= 4; k++) begin
            g = 4'b0001 << (k % 4);
            addVec(4'b1111, 4'b1111, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, g, 4'b0, 1'b1);
            addVec(4'b1111, 4'b1111, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, g, 4'b0, 1'b1);
            addVec(4'b1111, 4'b1111, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, g, 1'b0);
        end
        // Requester 2 served once (owner was 0, so keygen), decrypt.
        addVec(4'b0100, 4'b0000, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0, 1'b1);
        addVec(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0, 1'b1);
        addVec(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0);
        // Requester 2 again with a dirty key: keygen despite owning the key.
        // A stray encdec_done in KEYGEN (with a req change) is ignored, both
        // done pulses together act as key_done, key_done in CRYPT is ignored.
        addVec(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0, 1'b1);
        addVec(4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0, 1'b1);
        addVec(4'b0, 4'b0, 4'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0, 1'b1);
        addVec(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0, 1'b1);
        addVec(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0);
        // Requester 2 once more, key now clean: no keygen.
        addVec(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0, 1'b1);
        addVec(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0);
        // last_grant = 2, requesters 0 and 1 ask: search wraps 3 -> 0.
        addVec(4'b0011, 4'b0011, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0, 1'b1);
        addVec(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0, 1'b1);
        addVec(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        buildTable();

        // Reset state while reset is held.
        step();
        step();
        checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        reset = 1'b0;

        // Table-driven main flow.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].encDec, vecs[i].dirty,
                          vecs[i].keyDone, vecs[i].encDone);
            step();
            checkOutput($sformatf("vec%0d", i), vecs[i].expKs, vecs[i].expEs,
                        vecs[i].expDs, vecs[i].expGrant, vecs[i].expAck, 4'b0,
                        vecs[i].expBusy);
        end

        // Owner is 0 with a clean key, so this goes straight to CRYPT. Reset
        // lands 3 cycles into CRYPT; outputs must drop without an edge, no ack
        // may follow, and the same request afterwards must run keygen.
        runVec("rst_enc_start", 4'b0001, 4'b0001, 4'b0, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b0, 4'b0001, 4'b0, 4'b0, 1'b1);
        waitHeld("rst_crypt_hold", 3, 4'b0001);
        reset = 1'b1;
        #1;
        checkOutput("rst_async_drop", 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        encdec_done = 1'b1;
        step();
        step();
        checkOutput("rst_no_ack", 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        reset = 1'b0;
        runVec("rst_release_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        runVec("rst_keygen_again", 4'b0001, 4'b0001, 4'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0, 4'b0001, 4'b0, 4'b0, 1'b1);
        runVec("rst_enc_after_key", 4'b0, 4'b0, 4'b0, 1'b1, 1'b0,
               1'b0, 1'b1, 1'b0, 4'b0001, 4'b0, 4'b0, 1'b1);
        runVec("rst_ack", 4'b0, 4'b0, 4'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 4'b0, 4'b0001, 4'b0, 1'b0);

        // Make requester 1 the key owner (last_grant = 0, owner 0 -> keygen).
        runVec("own1_keygen", 4'b0010, 4'b0010, 4'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0, 4'b0010, 4'b0, 4'b0, 1'b1);
        runVec("own1_enc", 4'b0, 4'b0, 4'b0, 1'b1, 1'b0,
               1'b0, 1'b1, 1'b0, 4'b0010, 4'b0, 4'b0, 1'b1);
        runVec("own1_ack", 4'b0, 4'b0, 4'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 4'b0, 4'b0010, 4'b0, 1'b0);

`ifdef BORON_ARB_TIMEOUT_EN
        // Clean key -> dec_start; core never answers: err 16 cycles later.
        runVec("to_crypt_start", 4'b0010, 4'b0000, 4'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b1, 4'b0010, 4'b0, 4'b0, 1'b1);
        waitHeld("to_crypt_wait", 15, 4'b0010);
        runVec("to_crypt_err", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0010, 1'b0);
        // Key ownership was dropped: keygen, and key_done never comes.
        runVec("to_key_start", 4'b0010, 4'b0000, 4'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0, 4'b0010, 4'b0, 4'b0, 1'b1);
        waitHeld("to_key_wait", 15, 4'b0010);
        runVec("to_key_err", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0010, 1'b0);
        // encdec_done on the timeout cycle wins: ack, no err.
        runVec("to_race_keygen", 4'b0010, 4'b0010, 4'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0, 4'b0010, 4'b0, 4'b0, 1'b1);
        runVec("to_race_enc", 4'b0, 4'b0, 4'b0, 1'b1, 1'b0,
               1'b0, 1'b1, 1'b0, 4'b0010, 4'b0, 4'b0, 1'b1);
        waitHeld("to_race_wait", 15, 4'b0010);
        runVec("to_race_ack", 4'b0, 4'b0, 4'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 4'b0, 4'b0010, 4'b0, 1'b0);
`else
        // Without the watchdog a silent core simply keeps the grant.
        runVec("nowd_start", 4'b0010, 4'b0000, 4'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b1, 4'b0010, 4'b0, 4'b0, 1'b1);
        waitHeld("nowd_wait", 40, 4'b0010);
        runVec("nowd_ack", 4'b0, 4'b0, 4'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 4'b0, 4'b0010, 4'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boron_req_arbiter.md
Name: boron_req_arbiter

Overview:
Shares one BORON key-schedule + enc/dec core among NUM_REQ requesters. Picks a requester by round-robin, then drives the core start handshake: keygen, then encrypt or decrypt, then a completion ack. Caches key ownership so a repeat request from the same requester with an unchanged key skips keygen. Sits above the core's control unit and replaces the single start/enc_dec/done interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of grant_idx, equal to clog2(NUM_REQ)
TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature)
CNT_W, 11, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
req  input  NUM_REQ  per-requester request level
req_enc_dec  input  NUM_REQ  per-requester mode: 1 = encrypt, 0 = decrypt
key_dirty  input  NUM_REQ  requester's key has changed since its last keygen
key_done  input  1  core key schedule complete (pulse)
encdec_done  input  1  core enc/dec complete (pulse)
key_start  output  1  one-cycle pulse that starts keygen
enc_start  output  1  one-cycle pulse that starts encryption
dec_start  output  1  one-cycle pulse that starts decryption
grant  output  NUM_REQ  one-hot owner of the core; steers the data mux
grant_idx  output  IDX_W  binary index of the owner
ack  output  NUM_REQ  one-cycle completion pulse to the owner
err  output  NUM_REQ  one-cycle watchdog error pulse to the owner
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority; key_owner_valid = 0; key_owner = 0; watchdog = 0.
- All outputs are registered.
- States: IDLE, KEYGEN, CRYPT.
- IDLE: if any req bit is set, the winner is the first set bit searching upward from (last_grant+1) mod NUM_REQ, with wrap-around. On the next edge:
  - grant/grant_idx are set to the winner; mode is latched from req_enc_dec[winner]; busy = 1.
  - need_key = !key_owner_valid | key_owner != winner | key_dirty[winner].
  - If need_key: key_start pulses and state goes to KEYGEN.
  - Else: enc_start (mode = 1) or dec_start (mode = 0) pulses and state goes to CRYPT.
- KEYGEN: on key_done, enc_start or dec_start pulses per the latched mode. key_owner = grant_idx, key_owner_valid = 1, state goes to CRYPT.
- CRYPT: on encdec_done:
  - ack[grant_idx] pulses.
  - grant, grant_idx and busy clear on the same edge.
  - last_grant = grant_idx; state goes to IDLE.
- Latency: request to first start pulse = 1 cycle. Core done to the next start pulse or ack = 1 cycle. Minimum gap between operations = 1 IDLE cycle.
- Done inputs are sampled only in their own state. key_done seen in CRYPT, or encdec_done seen in KEYGEN, is ignored. Both arriving in KEYGEN: only key_done acts.
- Inputs are sampled only in IDLE: req, req_enc_dec and key_dirty changes while busy have no effect. A requester dropping req mid-operation does not abort it; ack still pulses.
- A requester that keeps req high after its ack is re-arbitrated at the lowest priority.
- key_dirty is a level the requester clears after its ack. The arbiter does not clear it.
- Asynchronous reset at any point, including mid-KEYGEN/CRYPT: outputs drop immediately, no ack is issued, key_owner_valid = 0, so the next request always runs keygen.
- At most one of key_start/enc_start/dec_start/ack/err is high in any cycle.

Optional Feature:
Macro BORON_ARB_TIMEOUT_EN.
- Defined:
  - The watchdog clears on every start pulse and increments each cycle in KEYGEN/CRYPT.
  - When it reaches TIMEOUT_CYCLES with no done: err[grant_idx] pulses instead of ack, grant clears, key_owner_valid = 0, last_grant = grant_idx, state goes to IDLE.
  - A done arriving in the same cycle as the timeout wins: normal ack, no err.
- Not defined: no watchdog logic; err is tied to 0; the block waits on done indefinitely.

Test Plan:
- After reset, req = 0001, req_enc_dec[0] = 1; key_done 5 cycles after key_start; encdec_done 10 cycles after enc_start. Required: key_start at cycle 1, grant = 0001; enc_start 1 cycle after key_done; ack = 0001 1 cycle after encdec_done; grant = 0 and busy = 0 at the same edge.
- Repeat req0 with req_enc_dec = 0 and key_dirty = 0. Required: no key_start; dec_start 1 cycle after req.
- last_grant = 0, req = 1111 held high. Required: grant order 0010, 0100, 1000, 0001; every grant change runs keygen.
- Requester 2 served, then requests again with key_dirty[2] = 1. Required: key_start reasserted, then enc/dec start.
- BORON_ARB_TIMEOUT_EN defined with TIMEOUT_CYCLES = 16, core never returns key_done. Required: err[owner] pulses 16 cycles after key_start, no ack; the next request from the same requester runs keygen. Also drive encdec_done on the timeout cycle: ack pulses, err does not.
- Assert reset 3 cycles into CRYPT. Required: all outputs 0 immediately and no ack pulse; after release, the same request runs keygen.
